button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
Multi-channel input conditioner for board-level buttons and switches. It replaces single-flop "debounce" registers in board top levels with three stages per channel:
- a configurable-depth synchroniser;
- a prescaled stability counter;
- registered press/release edge pulses.

It sits between board pins and the rvx reset_n/halt inputs (and any GPIO-style inputs), clocked by the core clock.

Parameters:
CHANNELS, 2, number of independent input channels.
TICK_DIVISOR, 50000, clock cycles per sample tick (1 ms at 50 MHz); minimum 1.
STABLE_TICKS, 10, consecutive ticks of disagreement required before a level change; minimum 1.
SYNC_STAGES, 2, synchroniser flops per channel; minimum 2.
RESET_VALUE, {CHANNELS{1'b0}}, per-channel reset value of the synchroniser and level_out.
HOLD_TICKS, 1000, ticks of continuous high level before held asserts; used only with the optional feature.

Ports:
clock  input  1  system clock; all state on its rising edge.
reset  input  1  asynchronous, active-high reset.
raw_in  input  CHANNELS  unsynchronised pin levels.
level_out  output  CHANNELS  debounced level per channel.
rise_pulse  output  CHANNELS  one-cycle pulse on a debounced 0->1 transition.
fall_pulse  output  CHANNELS  one-cycle pulse on a debounced 1->0 transition.
tick  output  1  one-cycle sample strobe from the prescaler (exported for sharing and test).
held  output  CHANNELS  long-press indicator; present only with BUTTON_DEBOUNCER_HOLD_EN.

Behaviour:
- Reset: asynchronous, active-high.
  - Prescaler clears to 0; tick=0.
  - Synchroniser flops and level_out load RESET_VALUE.
  - Stability counters clear to 0.
  - rise_pulse=0, fall_pulse=0, held=0.
  - No pulses are emitted on reset release, even when raw_in differs from RESET_VALUE.
- Prescaler:
  - Counter width is $clog2(TICK_DIVISOR), minimum 1.
  - Counts 0..TICK_DIVISOR-1 and wraps to 0.
  - tick is registered: high for exactly one cycle each time the counter wraps, i.e. period TICK_DIVISOR.
  - With TICK_DIVISOR=1, tick is high every cycle after the first post-reset edge.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Per-channel stability counter cnt[i], width $clog2(STABLE_TICKS+1):
  - If s[i]==level_out[i]: cnt[i] <= 0 on every cycle, regardless of tick. Any glitch that returns before the window completes is fully discarded.
  - If s[i]!=level_out[i] and tick=1 and cnt[i]==STABLE_TICKS-1:
    - level_out[i] <= s[i];
    - cnt[i] <= 0;
    - rise_pulse[i] <= s[i];
    - fall_pulse[i] <= ~s[i].
  - If s[i]!=level_out[i] and tick=1 otherwise: cnt[i] <= cnt[i]+1.
  - If s[i]!=level_out[i] and tick=0: cnt[i] holds.
- Pulse timing:
  - rise_pulse and fall_pulse default to 0 every cycle.
  - A pulse is high in the same cycle that level_out first shows the new value; width is exactly 1 cycle.
  - The minimum spacing between two pulses on one channel is STABLE_TICKS ticks.
- Latency:
  - Measured from the first edge that samples a new raw level, to level_out change.
  - Range is SYNC_STAGES-1 + (STABLE_TICKS-1)*TICK_DIVISOR + 1 to SYNC_STAGES-1 + STABLE_TICKS*TICK_DIVISOR edges.
  - The exact value depends on prescaler phase.
- Channels are fully independent. Simultaneous transitions on several channels in one cycle are all reported in that cycle.
- Reset asserted mid-count discards the count; no partial state survives.

Optional Feature:
Macro: BUTTON_DEBOUNCER_HOLD_EN.
- Defined:
  - Adds a per-channel hold counter that clears whenever level_out[i]=0.
  - While level_out[i]=1, the counter increments on tick and saturates at HOLD_TICKS.
  - held[i] is registered and goes high in the cycle the counter reaches HOLD_TICKS.
  - held[i] stays high until level_out[i] falls, then drops in the same cycle as fall_pulse[i].
- Not defined: the held port and the hold counters do not exist. All other behaviour is identical.

Test Plan (TICK_DIVISOR=4, STABLE_TICKS=3, SYNC_STAGES=2, CHANNELS=2, RESET_VALUE=0, HOLD_TICKS=5):
- Reset then idle, raw_in=2'b00 -> tick every 4 cycles; level_out=00; no pulses; held=00.
- raw_in[0] 0->1 held steady -> level_out[0] rises 10-13 edges after the first sampling edge; rise_pulse[0] is high for exactly that one cycle; channel 1 is unaffected.
- raw_in[0] 1-cycle and 6-cycle glitches high from level 0 -> level_out[0] stays 0; no pulses; cnt returns to 0.
- Both channels toggle in the same cycle after a steady state -> rise_pulse=11 in one cycle, later fall_pulse=11 in one cycle.
- raw_in=2'b11 with reset asserted asynchronously mid-count -> outputs go to 0 immediately without waiting for a clock edge; after release, level_out reaches 11 via a full debounce window; no pulse is emitted at the reset edge itself.
- HOLD_EN: level_out[1]=1 for 5 ticks -> held[1]=1; release -> held[1] and fall_pulse[1] drop and pulse, respectively, in the same cycle.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchroniser, tick-prescaled stability filter and press/release pulses.
// Define BUTTON_DEBOUNCER_HOLD_EN to add the per-channel long-press "held" output.
module button_debouncer #(
  parameter int CHANNELS = 2,
  parameter int TICK_DIVISOR = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}},
  parameter int HOLD_TICKS = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
`ifdef BUTTON_DEBOUNCER_HOLD_EN
  output logic [CHANNELS-1:0] held,
`endif
  output logic                tick
);
  localparam int PW = TICK_DIVISOR > 1 ? $clog2(TICK_DIVISOR) : 1;
  localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS + 1) : 1;
  logic [PW-1:0] pre;
  logic [CHANNELS-1:0] sync [SYNC_STAGES];
  logic [CHANNELS-1:0] s, fire, lvl_nxt;
  logic [CW-1:0] cnt [CHANNELS];
  logic [CW-1:0] cnt_nxt [CHANNELS];
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pre <= '0;
      tick <= 1'b0;
    end else begin
      tick <= pre == PW'(TICK_DIVISOR - 1);
      pre <= pre == PW'(TICK_DIVISOR - 1) ? '0 : pre + 1'b1;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= RESET_VALUE;
    end else begin
      sync[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  // Agreement with the current level wipes the count, so short glitches leave no trace.
  always_comb begin
    fire = '0;
    lvl_nxt = level_out;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = '0;
      fire[i] = (s[i] != level_out[i]) && tick && cnt[i] == CW'(STABLE_TICKS - 1);
      lvl_nxt[i] = fire[i] ? s[i] : level_out[i];
      cnt_nxt[i] = (s[i] == level_out[i] || fire[i]) ? '0 : tick ? cnt[i] + 1'b1 : cnt[i];
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      level_out <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      level_out <= lvl_nxt;
      rise_pulse <= fire & s;
      fall_pulse <= fire & ~s;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
    end
`ifdef BUTTON_DEBOUNCER_HOLD_EN
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS + 1) : 1;
  logic [HW-1:0] hcnt [CHANNELS];
  // Clearing on the next level lets held drop in the same cycle fall_pulse fires.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      held <= '0;
      for (int i = 0; i < CHANNELS; i++) hcnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (!lvl_nxt[i]) begin
          hcnt[i] <= '0;
          held[i] <= 1'b0;
        end else if (level_out[i] && tick && hcnt[i] != HW'(HOLD_TICKS)) begin
          hcnt[i] <= hcnt[i] + 1'b1;
          held[i] <= hcnt[i] == HW'(HOLD_TICKS - 1);
        end
    end
`endif
endmodule
